// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Imported by the top level and the digit correction cell.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_MAX = 9999;
    localparam logic [3:0] NIB_NINE = 4'd9;

endpackage

// File: rtl/dabble_adjust.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more,
// so the following left shift carries into the next decimal digit.
module dabble_adjust (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter, one input bit per clock.
// Digits and overflow are registered and only change on completion.
module bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 14
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [BIN_WIDTH-1:0] Bin,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Overflow,
    output logic [3:0]           BCD3,
    output logic [3:0]           BCD2,
    output logic [3:0]           BCD1,
    output logic [3:0]           BCD0
);

    localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] shift_q, shift_d;
    logic [15:0]          scratch_q, scratch_d;
    logic                 sat_q, sat_d;
    logic [15:0]          bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;

    logic [15:0]          adj;
    logic [15:0]          scratch_nxt;
    logic                 unused_carry;

    // Per-digit "add 3 if >= 5" correction of the current scratch.
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        dabble_adjust u_adj (
            .nib_i(scratch_q[4*g +: 4]),
            .nib_o(adj[4*g +: 4])
        );
    end

    // Corrected scratch shifted left, pulling in the next binary MSB.
    // The bit leaving the top is dropped; saturation covers that case.
    assign {unused_carry, scratch_nxt} = {adj, shift_q[BIN_WIDTH-1]};

    // Next-state, datapath and output-register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        sat_d     = sat_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d   = SHIFT;
                    shift_d   = Bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    sat_d     = 32'(Bin) > 32'(BCD_MAX);
                end
            end
            SHIFT: begin
                scratch_d = scratch_nxt;
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    if (sat_q) begin
                        bcd_d = {BCD_DIGITS{NIB_NINE}};
                        ovf_d = 1'b1;
                    end else begin
                        bcd_d = scratch_nxt;
                        ovf_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            sat_q     <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            sat_q     <= sat_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Busy     = (state_q != IDLE);
    assign Done     = (state_q == DONE);
    assign Overflow = ovf_q;
    assign BCD3     = bcd_q[15:12];
    assign BCD2     = bcd_q[11:8];
    assign BCD1     = bcd_q[7:4];
    assign BCD0     = bcd_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed and table-driven bench for bin_to_bcd at the default width.
// Covers latency, hold-until-done, saturation, ignored start, retrigger, reset.
module tb_bin_to_bcd;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [13:0] Bin;
    logic        Busy;
    logic        Done;
    logic        Overflow;
    logic [3:0]  BCD3, BCD2, BCD1, BCD0;

    int checks = 0;
    int failures = 0;
    logic [15:0] prev_bcd;
    logic        prev_ovf;

    typedef struct {
        int         bin;
        logic [3:0] d3, d2, d1, d0;
        logic       ovf;
    } vec_t;

    vec_t tbl [12];

    bin_to_bcd #(.BIN_WIDTH(14)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Bin(Bin),
        .Busy(Busy),
        .Done(Done),
        .Overflow(Overflow),
        .BCD3(BCD3),
        .BCD2(BCD2),
        .BCD1(BCD1),
        .BCD0(BCD0)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_conv(input int b, input logic [3:0] e3, input logic [3:0] e2,
                            input logic [3:0] e1, input logic [3:0] e0,
                            input logic eo, input int glitch);
        int   lat;
        logic held;
        lat = 0;
        held = 1'b1;
        @(negedge Clk);
        Start = 1'b1;
        Bin = 14'(b);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Bin = ~Bin;
        chk("busy_rise", 32'(Busy), 1);
        for (int i = 1; i <= 30; i++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                lat = i;
                break;
            end
            if ({BCD3, BCD2, BCD1, BCD0, Overflow} !== {prev_bcd, prev_ovf})
                held = 1'b0;
            if (i == glitch) begin
                Start = 1'b1;
                Bin = 14'd7;
            end else begin
                Start = 1'b0;
            end
        end
        Start = 1'b0;
        chk("latency", 32'(lat), 14);
        chk("hold_until_done", 32'(held), 1);
        chk("digits", 32'({BCD3, BCD2, BCD1, BCD0}), 32'({e3, e2, e1, e0}));
        chk("overflow", 32'(Overflow), 32'(eo));
        chk("busy_in_done", 32'(Busy), 1);
        @(posedge Clk);
        #1;
        chk("done_one_cycle", 32'(Done), 0);
        chk("busy_fall", 32'(Busy), 0);
        chk("digits_hold", 32'({BCD3, BCD2, BCD1, BCD0}), 32'({e3, e2, e1, e0}));
        prev_bcd = {e3, e2, e1, e0};
        prev_ovf = eo;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, nd, m;

        tbl[0]  = '{0,     4'd0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[1]  = '{1234,  4'd1, 4'd2, 4'd3, 4'd4, 1'b0};
        tbl[2]  = '{9999,  4'd9, 4'd9, 4'd9, 4'd9, 1'b0};
        tbl[3]  = '{10000, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1};
        tbl[4]  = '{16383, 4'd9, 4'd9, 4'd9, 4'd9, 1'b1};
        tbl[5]  = '{5,     4'd0, 4'd0, 4'd0, 4'd5, 1'b0};
        tbl[6]  = '{10,    4'd0, 4'd0, 4'd1, 4'd0, 1'b0};
        tbl[7]  = '{99,    4'd0, 4'd0, 4'd9, 4'd9, 1'b0};
        tbl[8]  = '{100,   4'd0, 4'd1, 4'd0, 4'd0, 1'b0};
        tbl[9]  = '{999,   4'd0, 4'd9, 4'd9, 4'd9, 1'b0};
        tbl[10] = '{1000,  4'd1, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[11] = '{8191,  4'd8, 4'd1, 4'd9, 4'd1, 1'b0};

        Reset = 1'b1;
        Start = 1'b0;
        Bin = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_digits", 32'({BCD3, BCD2, BCD1, BCD0}), 0);
        chk("reset_ovf", 32'(Overflow), 0);
        chk("reset_busy", 32'(Busy), 0);
        chk("reset_done", 32'(Done), 0);
        @(negedge Clk);
        Reset = 1'b0;
        prev_bcd = '0;
        prev_ovf = 1'b0;

        for (int t = 0; t < 12; t++)
            run_conv(tbl[t].bin, tbl[t].d3, tbl[t].d2, tbl[t].d1, tbl[t].d0,
                     tbl[t].ovf, 0);

        // Start pulsed mid-conversion must be ignored.
        run_conv(42, 4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 5);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            if (Done) nd++;
        end
        chk("ignored_start_no_done", 32'(nd), 0);
        chk("ignored_start_digits", 32'({BCD3, BCD2, BCD1, BCD0}), 32'h0042);

        // Start held high: back-to-back conversions.
        @(negedge Clk);
        Start = 1'b1;
        Bin = 14'd77;
        @(posedge Clk);
        #1;
        d1 = 0;
        d2 = 0;
        nd = 0;
        for (int i = 1; i <= 31; i++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                nd++;
                if (nd == 1) d1 = i;
                if (nd == 2) d2 = i;
            end
        end
        Start = 1'b0;
        chk("retrig_first", 32'(d1), 14);
        chk("retrig_second", 32'(d2), 30);
        chk("retrig_count", 32'(nd), 2);
        chk("retrig_digits", 32'({BCD3, BCD2, BCD1, BCD0}), 32'h0077);
        prev_bcd = 16'h0077;
        prev_ovf = 1'b0;
        repeat (3) @(posedge Clk);

        // Reset in the middle of a conversion.
        run_conv(5678, 4'd5, 4'd6, 4'd7, 4'd8, 1'b0, 0);
        @(negedge Clk);
        Start = 1'b1;
        Bin = 14'd321;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (8) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("midreset_digits", 32'({BCD3, BCD2, BCD1, BCD0}), 0);
        chk("midreset_ovf", 32'(Overflow), 0);
        chk("midreset_busy", 32'(Busy), 0);
        chk("midreset_done", 32'(Done), 0);
        @(negedge Clk);
        Reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge Clk);
            #1;
            if (Done) nd++;
        end
        chk("midreset_no_done", 32'(nd), 0);
        prev_bcd = '0;
        prev_ovf = 1'b0;
        run_conv(321, 4'd0, 4'd3, 4'd2, 4'd1, 1'b0, 0);

        // Strided sweep of the full input range against min(Bin, 9999).
        for (int v = 0; v < 16384; v += 61) begin
            m = (v > 9999) ? 9999 : v;
            run_conv(v, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10),
                     4'(m % 10), (v > 9999) ? 1'b1 : 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
